// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One operand bit is processed per RUN cycle; a final SIGN cycle applies
// the sign correction and writes HI/LO. Divide support is compiled in only
// when MUL_DIV_UNIT_DIV_EN is defined; otherwise divide requests are ignored.
module mul_div_unit #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         START,
    input  logic         SIGNED,
    input  logic         OP_DIV,
    input  logic [W-1:0] SRC_A,
    input  logic [W-1:0] SRC_B,
    input  logic [1:0]   READ_SEL,
    output logic [W-1:0] HILO_OUT,
    output logic         BUSY,
    output logic         STALL
);

    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;       // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [W-1:0]   opd;       // multiplicand or divisor magnitude
    logic           sign_a, sign_b;
    logic [W-1:0]   hi_q, lo_q;
    logic           accept;
    logic [W-1:0]   mag_a, mag_b;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_nxt;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   res_hi, res_lo;
    logic [2*W-1:0] step_nxt;

`ifdef MUL_DIV_UNIT_DIV_EN
    logic           div_q;
    logic           b_zero;
    logic [W:0]     rem_sh;
    logic [W:0]     diff;
    logic [2*W-1:0] div_nxt;
    assign accept = START && (state == IDLE);
`else
    assign accept = START && (state == IDLE) && !OP_DIV;
`endif

    assign mag_a = (SIGNED && SRC_A[W-1]) ? ('0 - SRC_A) : SRC_A;
    assign mag_b = (SIGNED && SRC_B[W-1]) ? ('0 - SRC_B) : SRC_B;

    // Shift-add multiply step: add multiplicand to the upper half when the
    // current multiplier LSB is set, then shift the whole register right.
    always_comb begin
        mul_sum = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opd : {W{1'b0}})};
        mul_nxt = {mul_sum, acc[W-1:1]};
    end

`ifdef MUL_DIV_UNIT_DIV_EN
    // Restoring divide step: shift in the next dividend bit, keep the
    // trial subtraction only when it does not go negative.
    always_comb begin
        rem_sh = {acc[2*W-1:W], acc[W-1]};
        diff   = rem_sh - {1'b0, opd};
        if (!diff[W])
            div_nxt = {diff[W-1:0], acc[W-2:0], 1'b1};
        else
            div_nxt = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
    end
`endif

    // Select the iteration step and the sign-corrected final result.
    always_comb begin
        step_nxt = mul_nxt;
        prod_fix = (sign_a ^ sign_b) ? ('0 - acc) : acc;
        res_hi   = prod_fix[2*W-1:W];
        res_lo   = prod_fix[W-1:0];
`ifdef MUL_DIV_UNIT_DIV_EN
        if (div_q) begin
            step_nxt = div_nxt;
            // Divide by zero keeps the all-ones quotient regardless of sign.
            res_lo = ((sign_a ^ sign_b) && !b_zero) ? ('0 - acc[W-1:0]) : acc[W-1:0];
            res_hi = sign_a ? ('0 - acc[2*W-1:W]) : acc[2*W-1:W];
        end
`endif
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic: W iteration cycles then one sign-fix cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (cnt == CW'(W - 1)) state_nxt = SIGN;
            SIGN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, and HI/LO write at SIGN exit.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt    <= '0;
            acc    <= '0;
            opd    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
`ifdef MUL_DIV_UNIT_DIV_EN
            div_q  <= 1'b0;
            b_zero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cnt    <= '0;
                    sign_a <= SIGNED & SRC_A[W-1];
                    sign_b <= SIGNED & SRC_B[W-1];
`ifdef MUL_DIV_UNIT_DIV_EN
                    div_q  <= OP_DIV;
                    b_zero <= (SRC_B == '0);
                    if (OP_DIV) begin
                        acc <= {{W{1'b0}}, mag_a};
                        opd <= mag_b;
                    end else begin
                        acc <= {{W{1'b0}}, mag_b};
                        opd <= mag_a;
                    end
`else
                    acc <= {{W{1'b0}}, mag_b};
                    opd <= mag_a;
`endif
                end
                RUN: begin
                    acc <= step_nxt;
                    cnt <= cnt + CW'(1);
                end
                SIGN: begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                    cnt  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign BUSY  = (state != IDLE);
    assign STALL = BUSY && (START || (READ_SEL == 2'b01) || (READ_SEL == 2'b10));

    // HI/LO read mux.
    always_comb begin
        case (READ_SEL)
            2'b01:   HILO_OUT = hi_q;
            2'b10:   HILO_OUT = lo_q;
            default: HILO_OUT = '0;
        endcase
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: table of operations plus hand-written
// sequences for stall/ignore/reset corners. Divide rows enabled by
// MUL_DIV_UNIT_DIV_EN.
module tb_mul_div_unit;
    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RESET_N = 1'b0;
    logic         START = 1'b0;
    logic         SIGNED = 1'b0;
    logic         OP_DIV = 1'b0;
    logic [W-1:0] SRC_A = '0;
    logic [W-1:0] SRC_B = '0;
    logic [1:0]   READ_SEL = 2'b00;
    logic [W-1:0] HILO_OUT;
    logic         BUSY;
    logic         STALL;

    int errors = 0;
    int checks = 0;

    mul_div_unit #(.W(W)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .SIGNED(SIGNED),
        .OP_DIV(OP_DIV), .SRC_A(SRC_A), .SRC_B(SRC_B), .READ_SEL(READ_SEL),
        .HILO_OUT(HILO_OUT), .BUSY(BUSY), .STALL(STALL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic         sgn;
        logic         div;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
        READ_SEL = 2'b01; #1 hi = HILO_OUT;
        READ_SEL = 2'b10; #1 lo = HILO_OUT;
        READ_SEL = 2'b00; #1;
    endtask

    // Issue one op at a negedge and wait (bounded) until BUSY falls.
    task automatic run_op(input logic sgn, input logic div, input logic [W-1:0] a,
                          input logic [W-1:0] b, output int busy_cycles);
        @(negedge CLK);
        SIGNED = sgn; OP_DIV = div; SRC_A = a; SRC_B = b; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        busy_cycles = 0;
        while (BUSY && busy_cycles < 200) begin
            busy_cycles++;
            @(negedge CLK);
        end
    endtask

    initial begin
        logic [W-1:0] hi, lo;
        int n;

        vecs.push_back('{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
        vecs.push_back('{1'b1, 1'b0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1});
        vecs.push_back('{1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
        vecs.push_back('{1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
        vecs.push_back('{1'b0, 1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780});
        vecs.push_back('{1'b1, 1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001});
        vecs.push_back('{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001});
        vecs.push_back('{1'b1, 1'b0, 32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000000});
        vecs.push_back('{1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF});
`ifdef MUL_DIV_UNIT_DIV_EN
        vecs.push_back('{1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD});
        vecs.push_back('{1'b0, 1'b1, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF});
        vecs.push_back('{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
        vecs.push_back('{1'b0, 1'b1, 32'd100,      32'd7,        32'd2,        32'd14});
        vecs.push_back('{1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF});
        vecs.push_back('{1'b1, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
        vecs.push_back('{1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF});
`endif

        // Reset state
        #12;
        chk("rst_busy", {31'b0, BUSY}, 32'd0);
        START = 1'b1; READ_SEL = 2'b01; #1;
        chk("rst_stall", {31'b0, STALL}, 32'd0);
        chk("rst_hi", HILO_OUT, 32'd0);
        START = 1'b0; READ_SEL = 2'b10; #1;
        chk("rst_lo", HILO_OUT, 32'd0);
        READ_SEL = 2'b00;
        @(negedge CLK); RESET_N = 1'b1;

        // Table-driven operations
        foreach (vecs[i]) begin
            run_op(vecs[i].sgn, vecs[i].div, vecs[i].a, vecs[i].b, n);
            chk($sformatf("v%0d_busy", i), n, W + 1);
            read_hilo(hi, lo);
            chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
        end

        // Read mux: 00 and 11 return 0
        READ_SEL = 2'b11; #1 chk("sel11", HILO_OUT, 32'd0);
        READ_SEL = 2'b00; #1 chk("sel00", HILO_OUT, 32'd0);

        // Preload HI=7, then stall/ignore sequence
        run_op(1'b0, 1'b0, 32'h70000000, 32'h00000010, n);
        read_hilo(hi, lo);
        chk("pre_hi", hi, 32'd7);
        chk("pre_lo", lo, 32'd0);
        @(negedge CLK);
        SIGNED = 1'b0; OP_DIV = 1'b0; SRC_A = 32'h80000000; SRC_B = 32'h4; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        n = 0;
        while (BUSY && n < 200) begin
            n++;
            if (n >= 5) READ_SEL = 2'b01;
            if (n == 10) begin
                SRC_A = 32'd3; SRC_B = 32'd3; START = 1'b1;
            end
            #1;
            if (n >= 5) begin
                chk($sformatf("stall_c%0d", n), {31'b0, STALL}, 32'd1);
                chk($sformatf("oldhi_c%0d", n), HILO_OUT, 32'd7);
            end
            @(negedge CLK);
            START = 1'b0;
        end
        chk("seq_busy", n, W + 1);
        #1;
        chk("seq_stall_off", {31'b0, STALL}, 32'd0);
        chk("seq_new_hi", HILO_OUT, 32'd2);
        READ_SEL = 2'b10; #1 chk("seq_new_lo", HILO_OUT, 32'd0);

        // START plus read in the same idle cycle
        READ_SEL = 2'b01;
        SRC_A = 32'd2; SRC_B = 32'd3; START = 1'b1; #1;
        chk("idle_rd_stall", {31'b0, STALL}, 32'd0);
        chk("idle_rd_hi", HILO_OUT, 32'd2);
        @(negedge CLK);
        START = 1'b0; READ_SEL = 2'b00;
        chk("idle_start_busy", {31'b0, BUSY}, 32'd1);
        n = 0;
        while (BUSY && n < 200) begin n++; @(negedge CLK); end
        read_hilo(hi, lo);
        chk("idle_op_lo", lo, 32'd6);

        // Reset mid-operation
        @(negedge CLK);
        SIGNED = 1'b0; SRC_A = 32'hFFFFFFFF; SRC_B = 32'hFFFFFFFF; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        READ_SEL = 2'b01; RESET_N = 1'b0; #1;
        chk("mid_rst_busy", {31'b0, BUSY}, 32'd0);
        chk("mid_rst_hi", HILO_OUT, 32'd0);
        READ_SEL = 2'b10; #1 chk("mid_rst_lo", HILO_OUT, 32'd0);
        READ_SEL = 2'b00;
        @(negedge CLK); RESET_N = 1'b1;
        run_op(1'b0, 1'b0, 32'd2, 32'd3, n);
        chk("post_rst_busy", n, W + 1);
        read_hilo(hi, lo);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd6);

`ifndef MUL_DIV_UNIT_DIV_EN
        // Divide requests ignored without divider
        @(negedge CLK);
        OP_DIV = 1'b1; SRC_A = 32'd9; SRC_B = 32'd3; START = 1'b1;
        @(negedge CLK);
        START = 1'b0; OP_DIV = 1'b0;
        chk("nodiv_busy", {31'b0, BUSY}, 32'd0);
        @(negedge CLK);
        chk("nodiv_busy2", {31'b0, BUSY}, 32'd0);
        read_hilo(hi, lo);
        chk("nodiv_hi", hi, 32'd0);
        chk("nodiv_lo", lo, 32'd6);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one parameter: W, default 32, operand and HI/LO register width.
REQ-002 The block SHALL have port CLK, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RESET_N, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port START, input, 1: operation request, driven by the decoder MULTIPLY control.
REQ-005 The block SHALL have port SIGNED, input, 1: 1 = signed operands (MULT/DIV), 0 = unsigned (MULTU/DIVU).
REQ-006 The block SHALL have port OP_DIV, input, 1: 0 = multiply, 1 = divide.
REQ-007 The block SHALL have ports SRC_A and SRC_B, input, W each: operands (multiplicand/dividend, multiplier/divisor).
REQ-008 The block SHALL have port READ_SEL, input, 2: the decoder MFCOP_SEL code (00 ALU, 01 HI, 10 LO, 11 COP0).
REQ-009 The block SHALL have port HILO_OUT, output, W: the selected HI/LO value.
REQ-010 The block SHALL have port BUSY, output, 1: an operation is in progress.
REQ-011 The block SHALL have port STALL, output, 1: pipeline hold request.

Function
REQ-012 The block SHALL implement states IDLE, RUN and SIGN.
- IDLE->RUN on START.
- RUN->SIGN after exactly W cycles.
- SIGN->IDLE after 1 cycle.
REQ-013 The block SHALL accept START only in IDLE: it latches operand magnitudes (two's-complement absolute value if SIGNED, else raw), SIGNED, OP_DIV and the operand signs.
REQ-014 Multiply SHALL be radix-2 iterative shift-add, one multiplier bit per RUN cycle, with a 2W-bit product.
REQ-015 In SIGN the block SHALL negate the 2W-bit product when SIGNED=1 and the operand signs differ, then write HI=upper W bits and LO=lower W bits.
REQ-016 Magnitude of -2^(W-1) SHALL be 2^(W-1) in W-bit unsigned, with no overflow special case.
REQ-017 BUSY SHALL be high in RUN and SIGN, i.e. exactly W+1 cycles after the START edge; HI/LO SHALL be updated on the edge leaving SIGN and readable the cycle BUSY falls.
REQ-018 HILO_OUT SHALL be combinational: READ_SEL 01 -> HI, 10 -> LO, 00/11 -> 0.
REQ-019 STALL SHALL be combinational and equal BUSY AND (START OR READ_SEL==01 OR READ_SEL==10).
REQ-020 START while BUSY SHALL be ignored, with no restart and no operand latch.
REQ-021 A read while BUSY SHALL return the pre-operation HI/LO value.
REQ-022 START and a HI/LO read in the same IDLE cycle SHALL return the old value with STALL=0, and the operation SHALL start.
REQ-023 HI/LO SHALL change only at SIGN exit or reset.

Reset
REQ-024 On RESET_N low, asynchronously, the block SHALL set state=IDLE, HI=0, LO=0, BUSY=0 and clear internal counters/accumulators.
- This applies mid-operation: the partial result is discarded and HI/LO are not written.
REQ-025 While in reset, STALL SHALL be 0 and HILO_OUT SHALL be 0.
REQ-026 After reset release, the first START SHALL be accepted on the next rising edge.

Configuration
REQ-027 With macro MUL_DIV_UNIT_DIV_EN defined, OP_DIV=1 SHALL run restoring division (one quotient bit per RUN cycle, W cycles, same W+1 latency) with LO=quotient and HI=remainder.
- In SIGN: negate the quotient if SIGNED and signs differ; negate the remainder if SIGNED and SRC_A was negative.
REQ-028 With MUL_DIV_UNIT_DIV_EN defined, divide by zero SHALL raise no exception and give LO=all ones and HI=SRC_A.
- This holds for unsigned and for signed operation.
REQ-029 With MUL_DIV_UNIT_DIV_EN defined, signed -2^(W-1)/-1 SHALL give LO=0x80000000 and HI=0.
REQ-030 Without MUL_DIV_UNIT_DIV_EN, START with OP_DIV=1 SHALL be ignored: BUSY stays 0, HI/LO are unchanged and no divider logic is synthesized.

Verification
REQ-031 Unsigned 0xFFFFFFFF*0xFFFFFFFF -> BUSY high 33 cycles, then HI=0xFFFFFFFE and LO=0x00000001.
REQ-032 Signed -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; signed 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
REQ-033 Preload HI=7 (via a prior 7<<32 product), START, then READ_SEL=01 at cycle 5 -> STALL=1 and HILO_OUT=old HI until BUSY falls.
- Then STALL=0 and the new HI is shown.
- A second START at cycle 10 is ignored.
REQ-034 RESET_N low at cycle 10 of a multiply -> BUSY=0, HI=LO=0 immediately; a new multiply 2*3 after release -> LO=6, HI=0.
REQ-035 With MUL_DIV_UNIT_DIV_EN:
- Signed -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Unsigned 5/0 -> LO=0xFFFFFFFF, HI=5.
- 0x80000000/0xFFFFFFFF signed -> LO=0x80000000, HI=0.
REQ-036 Without MUL_DIV_UNIT_DIV_EN, START with OP_DIV=1 and operands 9/3 -> BUSY stays 0 and HI/LO are unchanged.
